// File: rtl/wb_sync_bridge_buf.sv
// Single-clock buffered Wishbone bridge: posted-write command FIFO plus blocking read path to one slave.
// Optional feature: define WB_BRIDGE_TIMEOUT_EN to add a slave-timeout watchdog on the REQ state.
module wb_sync_bridge_buf #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int BW     = 4,
    parameter int CMD_DP = 4,
    parameter int TO_W   = 8,
    parameter int TO_CYC = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n,
    input  logic                      wbm_cyc_i,
    input  logic                      wbm_stb_i,
    input  logic [AW-1:0]             wbm_adr_i,
    input  logic                      wbm_we_i,
    input  logic [DW-1:0]             wbm_dat_i,
    input  logic [BW-1:0]             wbm_sel_i,
    output logic [DW-1:0]             wbm_dat_o,
    output logic                      wbm_ack_o,
    output logic                      wbm_err_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [AW-1:0]             wbs_adr_o,
    output logic                      wbs_we_o,
    output logic [DW-1:0]             wbs_dat_o,
    output logic [BW-1:0]             wbs_sel_o,
    input  logic [DW-1:0]             wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    output logic                      wr_err_o,
    input  logic                      wr_err_clr_i,
    output logic [$clog2(CMD_DP):0]   cmd_lvl_o
);
    localparam int PW = $clog2(CMD_DP);
    localparam logic [PW:0] LVL_FULL = (PW+1)'(CMD_DP);

    if (CMD_DP < 2 || (CMD_DP & (CMD_DP - 1)) != 0 || TO_CYC < 1 || TO_CYC >= (1 << TO_W)) begin : g_param_chk
        $error("wb_sync_bridge_buf: illegal CMD_DP / TO_CYC / TO_W combination");
    end

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    state_t state, state_nxt;

    logic [AW-1:0] fifo_adr [CMD_DP];
    logic          fifo_we  [CMD_DP];
    logic [DW-1:0] fifo_dat [CMD_DP];
    logic [BW-1:0] fifo_sel [CMD_DP];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   cnt;

    logic          full, empty, cmd_push, pop, slv_err, timeout, head_we, rd_ack;
    logic          rd_pend, wr_err;
    logic          resp_vld_p1, resp_err_p1;
    logic [DW-1:0] resp_dat_p1;

    assign full    = (cnt == LVL_FULL);
    assign empty   = (cnt == '0);
    // Reset also masks the combinational write ack so every output is 0 while held in reset.
    assign cmd_push = wb_rst_n & wbm_cyc_i & wbm_stb_i & ~rd_pend & ~full;
    assign rd_ack   = resp_vld_p1 & wbm_stb_i & ~wbm_we_i;
    assign head_we  = fifo_we[rd_ptr];
    assign slv_err  = wbs_err_i | timeout;
    assign pop      = (state == REQ) & (wbs_ack_i | wbs_err_i | timeout);

`ifdef WB_BRIDGE_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    // Fires in the TO_CYC-th REQ cycle, so an unresponsive slave sees the strobe for exactly TO_CYC cycles.
    assign timeout = (state == REQ) && (to_cnt == TO_W'(TO_CYC - 1)) && !wbs_ack_i && !wbs_err_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n)          to_cnt <= '0;
        else if (state != REQ)  to_cnt <= '0;
        else                    to_cnt <= to_cnt + TO_W'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    // Command FIFO storage (data only, pointers carry the reset state)
    always_ff @(posedge wb_clk_i) begin
        if (cmd_push) begin
            fifo_adr[wr_ptr] <= wbm_adr_i;
            fifo_we[wr_ptr]  <= wbm_we_i;
            fifo_dat[wr_ptr] <= wbm_dat_i;
            fifo_sel[wr_ptr] <= wbm_sel_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            rd_pend     <= 1'b0;
            resp_vld_p1 <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)      rd_ptr <= rd_ptr + PW'(1);
            case ({cmd_push, pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (cmd_push && !wbm_we_i) rd_pend <= 1'b1;
            else if (rd_ack)           rd_pend <= 1'b0;
            if (pop && !head_we)       resp_vld_p1 <= 1'b1;
            else if (rd_ack)           resp_vld_p1 <= 1'b0;
            if (pop && head_we && slv_err) wr_err <= 1'b1;
            else if (wr_err_clr_i)         wr_err <= 1'b0;
        end
    end

    // Read response stage: captured on slave completion, presented to the master one cycle later
    always_ff @(posedge wb_clk_i) begin
        if (pop && !head_we) begin
            resp_dat_p1 <= timeout ? '0 : wbs_dat_i;
            resp_err_p1 <= slv_err;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = REQ;
            REQ:     if (pop)    state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wbs_cyc_o = (state == REQ);
    assign wbs_stb_o = (state == REQ);
    assign wbs_adr_o = (state == REQ) ? fifo_adr[rd_ptr] : '0;
    assign wbs_we_o  = (state == REQ) & head_we;
    assign wbs_dat_o = (state == REQ) ? fifo_dat[rd_ptr] : '0;
    assign wbs_sel_o = (state == REQ) ? fifo_sel[rd_ptr] : '0;

    assign wbm_ack_o = (cmd_push & wbm_we_i) | rd_ack;
    assign wbm_dat_o = resp_vld_p1 ? resp_dat_p1 : '0;
    assign wbm_err_o = resp_vld_p1 & resp_err_p1;
    assign wr_err_o  = wr_err;
    assign cmd_lvl_o = cnt;

endmodule

// File: tb/tb_wb_sync_bridge_buf.sv
// Self-checking bench for wb_sync_bridge_buf: transaction-level model checked every cycle plus directed literal checks.
module tb_wb_sync_bridge_buf;
    localparam int AW = 32, DW = 32, BW = 4, DP = 4, LW = $clog2(DP) + 1, TO_CYC = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          m_cyc = 0, m_stb = 0, m_we = 0, clr = 0;
    logic [AW-1:0] m_adr = '0;
    logic [DW-1:0] m_dat = '0;
    logic [BW-1:0] m_sel = '0;
    logic [DW-1:0] wbm_dat_o, wbs_dat_o;
    logic          wbm_ack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wr_err_o;
    logic [AW-1:0] wbs_adr_o;
    logic [BW-1:0] wbs_sel_o;
    logic [LW-1:0] cmd_lvl_o;
    logic          s_ack = 0, s_err = 0;
    logic [DW-1:0] s_dat = '0;

    wb_sync_bridge_buf #(.AW(AW), .DW(DW), .BW(BW), .CMD_DP(DP), .TO_W(8), .TO_CYC(TO_CYC)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_adr_i(m_adr), .wbm_we_i(m_we),
        .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o),
        .wbm_err_o(wbm_err_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_adr_o(wbs_adr_o),
        .wbs_we_o(wbs_we_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_dat_i(s_dat),
        .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wr_err_o(wr_err_o), .wr_err_clr_i(clr),
        .cmd_lvl_o(cmd_lvl_o)
    );

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave responder: zero-wait ack (or err) while enabled
    logic          slv_en = 0, slv_err_mode = 0;
    logic [DW-1:0] slv_rdata = '0;
    always @(posedge clk) begin
        #2;
        s_ack = slv_en & wbs_stb_o & ~slv_err_mode;
        s_err = slv_en & wbs_stb_o & slv_err_mode;
        s_dat = (wbs_stb_o & ~wbs_we_o) ? slv_rdata : '0;
    end

    // Transaction-level model: queue of accepted commands, occupancy, pending read, response, sticky error
    typedef struct packed {
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] dat;
        logic [BW-1:0] sel;
    } cmd_t;
    cmd_t          exp_q[$];
    cmd_t          e;
    logic [AW-1:0] seen_adr[$];
    int            m_lvl = 0, m_req_cyc = 0, stb_cycles = 0;
    bit            m_rd_pend, m_resp_vld, m_resp_err, m_wr_err, m_gap;
    bit            m_push, m_rack, done, to_now, set_err;
    logic [DW-1:0] m_resp_dat;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_wbm_ack", 64'(wbm_ack_o), 64'(0));
            check("rst_wbs_stb", 64'(wbs_stb_o | wbs_cyc_o), 64'(0));
            check("rst_lvl", 64'(cmd_lvl_o), 64'(0));
            check("rst_wr_err", 64'(wr_err_o), 64'(0));
            check("rst_wbm_dat", 64'({wbm_dat_o, wbm_err_o}), 64'(0));
            exp_q.delete();
            m_lvl = 0; m_req_cyc = 0;
            m_rd_pend = 0; m_resp_vld = 0; m_resp_err = 0; m_wr_err = 0; m_gap = 0;
            m_resp_dat = '0;
        end else begin
            m_push = m_cyc & m_stb & !m_rd_pend & (m_lvl < DP);
            m_rack = m_resp_vld & m_stb & !m_we;
            check("cmd_lvl", 64'(cmd_lvl_o), 64'(m_lvl));
            check("wbm_ack", 64'(wbm_ack_o), 64'((m_push & m_we) | m_rack));
            check("wbm_dat", 64'(wbm_dat_o), 64'(m_resp_vld ? m_resp_dat : '0));
            check("wbm_err", 64'(wbm_err_o), 64'(m_resp_vld & m_resp_err));
            check("wr_err", 64'(wr_err_o), 64'(m_wr_err));
            check("cyc_eq_stb", 64'(wbs_cyc_o), 64'(wbs_stb_o));
            if (m_gap || m_lvl == 0) check("stb_low_gap_or_empty", 64'(wbs_stb_o), 64'(0));
            if (wbs_stb_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL slv_unexpected: strobe with adr 0x%0h, expected no command", wbs_adr_o);
                end else begin
                    check("slv_adr", 64'(wbs_adr_o), 64'(exp_q[0].adr));
                    check("slv_we", 64'(wbs_we_o), 64'(exp_q[0].we));
                    check("slv_dat", 64'(wbs_dat_o), 64'(exp_q[0].dat));
                    check("slv_sel", 64'(wbs_sel_o), 64'(exp_q[0].sel));
                end
            end else begin
                check("slv_idle_zero", 64'(|{wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o}), 64'(0));
            end

            to_now = 0;
`ifdef WB_BRIDGE_TIMEOUT_EN
            to_now = wbs_stb_o & !s_ack & !s_err & (m_req_cyc + 1 == TO_CYC);
`endif
            done = wbs_stb_o & (s_ack | s_err | to_now);
            if (wbs_stb_o) stb_cycles++;
            if (m_rack) begin m_resp_vld = 0; m_rd_pend = 0; end
            set_err = 0;
            if (done) seen_adr.push_back(wbs_adr_o);
            if (done && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.we) set_err = s_err | to_now;
                else begin
                    m_resp_vld = 1;
                    m_resp_err = s_err | to_now;
                    m_resp_dat = to_now ? '0 : s_dat;
                end
            end
            if (set_err)  m_wr_err = 1;
            else if (clr) m_wr_err = 0;
            if (m_push) begin
                exp_q.push_back(cmd_t'{adr: m_adr, we: m_we, dat: m_dat, sel: m_sel});
                if (!m_we) m_rd_pend = 1;
            end
            m_lvl     = m_lvl + int'(m_push) - int'(done);
            m_gap     = done;
            m_req_cyc = (wbs_stb_o && !done) ? m_req_cyc + 1 : 0;
        end
    end

    task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int waits);
        m_cyc = 1; m_stb = 1; m_we = 1; m_adr = a; m_dat = d; m_sel = 4'hF; waits = 0;
        @(negedge clk);
        while (!wbm_ack_o && waits < 200) begin waits++; @(negedge clk); end
        if (!wbm_ack_o) begin
            n_checks++; n_fail++;
            $display("FAIL write_ack_timeout: adr 0x%0h got no ack, expected ack", a);
        end
        @(posedge clk); #1;
        m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_dat = '0; m_sel = '0;
    endtask

    task automatic wb_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic er, output int waits);
        m_cyc = 1; m_stb = 1; m_we = 0; m_adr = a; m_dat = '0; m_sel = 4'hF; waits = 0;
        @(negedge clk);
        while (!wbm_ack_o && waits < 200) begin waits++; @(negedge clk); end
        if (!wbm_ack_o) begin
            n_checks++; n_fail++;
            $display("FAIL read_ack_timeout: adr 0x%0h got no ack, expected ack", a);
        end
        d = wbm_dat_o; er = wbm_err_o;
        @(posedge clk); #1;
        m_cyc = 0; m_stb = 0; m_adr = '0; m_sel = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((cmd_lvl_o != '0 || wbs_stb_o) && n < 300) begin n++; @(negedge clk); end
        check("drain_lvl", 64'(cmd_lvl_o), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int            w;
        logic [DW-1:0] rd;
        logic          re;

        repeat (3) @(posedge clk);
        #1;
        check("reset_lvl", 64'(cmd_lvl_o), 64'(0));
        check("reset_ack", 64'(wbm_ack_o), 64'(0));
        rst_n = 1;
        @(posedge clk); #1;

        // Three posted writes into a stalled slave, then drain in order
        seen_adr.delete();
        wb_write(32'h10, 32'hA0, w); check("wr0_zero_wait", 64'(w), 64'(0));
        wb_write(32'h14, 32'hA1, w); check("wr1_zero_wait", 64'(w), 64'(0));
        wb_write(32'h18, 32'hA2, w); check("wr2_zero_wait", 64'(w), 64'(0));
        @(negedge clk);
        check("lvl_after_3_writes", 64'(cmd_lvl_o), 64'(3));
        @(posedge clk); #1;
        slv_en = 1;
        wait_drain();
        check("seen_count", 64'(seen_adr.size()), 64'(3));
        if (seen_adr.size() == 3) begin
            check("seen_0", 64'(seen_adr[0]), 64'(32'h10));
            check("seen_1", 64'(seen_adr[1]), 64'(32'h14));
            check("seen_2", 64'(seen_adr[2]), 64'(32'h18));
        end

        // Full FIFO: fifth write stalls until the first pop, full sampled before the pop
        slv_en = 0;
        for (int i = 0; i < 4; i++) begin
            wb_write(32'h100 + 32'(4 * i), 32'h5500 + 32'(i), w);
            check("fill_zero_wait", 64'(w), 64'(0));
        end
        @(negedge clk);
        check("lvl_full", 64'(cmd_lvl_o), 64'(4));
        @(posedge clk); #1;
        fork
            wb_write(32'h110, 32'h5504, w);
            begin repeat (4) @(posedge clk); #1; slv_en = 1; end
        join
        check("fifth_write_stall", 64'(w), 64'(5));
        wait_drain();

        // Read ordered behind two writes
        seen_adr.delete();
        slv_rdata = 32'hDEADBEEF;
        wb_write(32'h200, 32'h1, w);
        wb_write(32'h204, 32'h2, w);
        wb_read(32'h20, rd, re, w);
        check("rd_data", 64'(rd), 64'(32'hDEADBEEF));
        check("rd_err", 64'(re), 64'(0));
        check("rd_order_count", 64'(seen_adr.size()), 64'(3));
        if (seen_adr.size() == 3) check("rd_after_writes", 64'(seen_adr[2]), 64'(32'h20));
        wait_drain();

        // Minimum read latency with an empty FIFO and zero-wait slave
        slv_rdata = 32'h12345678;
        wb_read(32'h24, rd, re, w);
        check("rd_min_latency", 64'(w >= 3), 64'(1));
        check("rd2_data", 64'(rd), 64'(32'h12345678));

        // Master drops strobe while the read is pending; response held until the next read strobe
        slv_en = 0;
        slv_rdata = 32'hCAFE0001;
        m_cyc = 1; m_stb = 1; m_we = 0; m_adr = 32'h28; m_sel = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        m_cyc = 0; m_stb = 0; m_adr = '0;
        slv_en = 1;
        repeat (6) @(posedge clk);
        #1;
        wb_read(32'h28, rd, re, w);
        check("held_resp_zero_wait", 64'(w), 64'(0));
        check("held_resp_data", 64'(rd), 64'(32'hCAFE0001));

        // Posted-write error: sticky, cleared by pulse, set wins over a coincident clear
        slv_err_mode = 1;
        wb_write(32'h30, 32'hE0, w);
        wait_drain();
        @(negedge clk);
        check("wr_err_set", 64'(wr_err_o), 64'(1));
        @(posedge clk); #1; clr = 1;
        @(posedge clk); #1; clr = 0;
        @(negedge clk);
        check("wr_err_cleared", 64'(wr_err_o), 64'(0));
        @(posedge clk); #1;
        wb_write(32'h34, 32'hE1, w);
        @(posedge clk); #1; clr = 1;
        @(posedge clk); #1; clr = 0;
        @(negedge clk);
        check("wr_err_set_wins", 64'(wr_err_o), 64'(1));
        @(posedge clk); #1;
        slv_err_mode = 0;
        clr = 1;
        @(posedge clk); #1; clr = 0;

`ifdef WB_BRIDGE_TIMEOUT_EN
        // Unresponsive slave: forced completion after TO_CYC strobe cycles
        slv_en = 0;
        stb_cycles = 0;
        wb_read(32'h40, rd, re, w);
        check("to_err", 64'(re), 64'(1));
        check("to_dat", 64'(rd), 64'(0));
        check("to_stb_cycles", 64'(stb_cycles), 64'(TO_CYC));
        slv_en = 1;
`endif

        // Reset with three queued writes and a pending read
        slv_en = 0;
        wb_write(32'h50, 32'h50, w);
        wb_write(32'h54, 32'h54, w);
        wb_write(32'h58, 32'h58, w);
        m_cyc = 1; m_stb = 1; m_we = 0; m_adr = 32'h60; m_sel = 4'hF;
        @(posedge clk);
        #3;
        rst_n = 0;
        m_we = 1;
        #1;
        check("async_rst_ack", 64'(wbm_ack_o), 64'(0));
        check("async_rst_stb", 64'(wbs_stb_o | wbs_cyc_o), 64'(0));
        check("async_rst_lvl", 64'(cmd_lvl_o), 64'(0));
        check("async_rst_slv_bus", 64'(|{wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o}), 64'(0));
        check("async_rst_master_resp", 64'({wbm_dat_o, wbm_err_o, wr_err_o}), 64'(0));
        m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0; m_sel = '0;
        @(posedge clk); #1;
        rst_n = 1;
        slv_en = 1;
        stb_cycles = 0;
        repeat (10) @(negedge clk);
        check("no_stale_slave_cycle", 64'(stb_cycles), 64'(0));
        check("post_rst_lvl", 64'(cmd_lvl_o), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global timeout");
    end
endmodule
